// File: rtl/washing_machine_plant.sv
// Drum/sensor plant model for the washing-machine controller: water level, detergent dosing,
// wash/spin timers, a debug phase tracker and a sticky illegal-command flag.
module washing_machine_plant #(
    parameter int unsigned LEVEL_W     = 8,
    parameter int unsigned FULL_LEVEL  = 200,
    parameter int unsigned FILL_RATE   = 4,
    parameter int unsigned DRAIN_RATE  = 8,
    parameter int unsigned DOSE_CYCLES = 5,
    parameter int unsigned WASH_CYCLES = 50,
    parameter int unsigned SPIN_CYCLES = 30,
    parameter int unsigned TMR_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               door_lock,
    input  logic               fill_valve_on,
    input  logic               drain_valve_on,
    input  logic               motor_on,
    input  logic               soap_wash,
    input  logic               water_wash,
    output logic               filled,
    output logic               drained,
    output logic               detergent_added,
    output logic               cycle_time_out,
    output logic               spin_time_out,
    output logic [LEVEL_W-1:0] level,
    output logic [2:0]         phase,
    output logic               fault
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFilling  = 3'd1,
        StWashing  = 3'd2,
        StDraining = 3'd3,
        StSpinning = 3'd4
    } phase_e;

    localparam int unsigned LW = LEVEL_W + 1;
    localparam logic [LW-1:0] FULL_W  = LW'(FULL_LEVEL);
    localparam logic [LW-1:0] FILL_W  = LW'(FILL_RATE);
    localparam logic [LW-1:0] DRAIN_W = LW'(DRAIN_RATE);

    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LW-1:0]      lvl_fill, lvl_wide;
    logic               filled_q, drained_q, filled_d, drained_d;
    logic [TMR_W-1:0]   dose_cnt_q, dose_cnt_d, wash_cnt_q, wash_cnt_d, spin_cnt_q, spin_cnt_d;
    logic               det_q, det_d, cto_q, cto_d, sto_q, sto_d;
    logic               fault_q, fault_d, quiet, quiet_q;
    logic               dose_run, wash_run, spin_run;
    phase_e             state_q, state_d;

    // Fill then drain, each saturating, in one extra bit so nothing wraps.
    always_comb begin
        lvl_fill = {1'b0, level_q};
        if (fill_valve_on) begin
            lvl_fill = lvl_fill + FILL_W;
            if (lvl_fill > FULL_W) lvl_fill = FULL_W;
        end
        lvl_wide = lvl_fill;
        if (drain_valve_on) begin
            lvl_wide = (lvl_fill > DRAIN_W) ? (lvl_fill - DRAIN_W) : '0;
        end
        level_d   = lvl_wide[LEVEL_W-1:0];
        filled_d  = (lvl_wide == FULL_W);
        drained_d = (lvl_wide == '0);
    end

    assign dose_run = soap_wash && filled_d && !drain_valve_on;
    assign wash_run = motor_on && !drain_valve_on && !drained_d;
    assign spin_run = motor_on && drain_valve_on && drained_d;

    always_comb begin
        dose_cnt_d = dose_cnt_q;
        det_d      = det_q;
        if (!dose_run) begin
            dose_cnt_d = '0;
        end else if (!det_q) begin
            if (dose_cnt_q == TMR_W'(DOSE_CYCLES - 1)) det_d = 1'b1;
            else dose_cnt_d = dose_cnt_q + TMR_W'(1);
        end
        // Draining to empty wins over a same-cycle dose completion.
        if (drained_d && drain_valve_on) det_d = 1'b0;
    end

    always_comb begin
        wash_cnt_d = wash_cnt_q;
        cto_d      = cto_q;
        if (!motor_on) begin
            wash_cnt_d = '0;
            cto_d      = 1'b0;
        end else if (wash_run && !cto_q) begin
            if (wash_cnt_q == TMR_W'(WASH_CYCLES - 1)) cto_d = 1'b1;
            else wash_cnt_d = wash_cnt_q + TMR_W'(1);
        end
    end

    always_comb begin
        spin_cnt_d = spin_cnt_q;
        sto_d      = sto_q;
        if (!motor_on || !drain_valve_on) begin
            spin_cnt_d = '0;
            sto_d      = 1'b0;
        end else if (spin_run && !sto_q) begin
            if (spin_cnt_q == TMR_W'(SPIN_CYCLES - 1)) sto_d = 1'b1;
            else spin_cnt_d = spin_cnt_q + TMR_W'(1);
        end
    end

    assign fault_d = fault_q
                   | (fill_valve_on && drain_valve_on)
                   | (motor_on && !door_lock)
                   | (fill_valve_on && !door_lock)
                   | (soap_wash && water_wash)
                   | (fill_valve_on && (({1'b0, level_q} + FILL_W) > FULL_W));

    assign quiet = !fill_valve_on && !drain_valve_on && !motor_on && drained_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (fill_valve_on) state_d = StFilling;
            StFilling:  if (motor_on && filled_q) state_d = StWashing;
            StWashing:  if (drain_valve_on) state_d = StDraining;
            StDraining: begin
                if (motor_on && drained_q) state_d = StSpinning;
                else if (fill_valve_on && drained_q) state_d = StFilling;
            end
            StSpinning: if (sto_q && !motor_on) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        // Two consecutive all-off cycles on an empty drum park the plant.
        if (quiet && quiet_q) state_d = StIdle;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q    <= '0;
            filled_q   <= 1'b0;
            drained_q  <= 1'b1;
            dose_cnt_q <= '0;
            det_q      <= 1'b0;
            wash_cnt_q <= '0;
            cto_q      <= 1'b0;
            spin_cnt_q <= '0;
            sto_q      <= 1'b0;
            fault_q    <= 1'b0;
            quiet_q    <= 1'b0;
            state_q    <= StIdle;
        end else begin
            level_q    <= level_d;
            filled_q   <= filled_d;
            drained_q  <= drained_d;
            dose_cnt_q <= dose_cnt_d;
            det_q      <= det_d;
            wash_cnt_q <= wash_cnt_d;
            cto_q      <= cto_d;
            spin_cnt_q <= spin_cnt_d;
            sto_q      <= sto_d;
            fault_q    <= fault_d;
            quiet_q    <= quiet;
            state_q    <= state_d;
        end
    end

    assign level           = level_q;
    assign filled          = filled_q;
    assign drained         = drained_q;
    assign detergent_added = det_q;
    assign cycle_time_out  = cto_q;
    assign spin_time_out   = sto_q;
    assign fault           = fault_q;
    assign phase           = state_q;

endmodule
